uart_word_assembler: RTL and testbench
======================================

# uart_word_assembler

- Receive-side deframer between `uart_rx` and the BIP data path.
- Collects `NBITS_D/DBIT` consecutive received bytes into one data word and presents it on a valid/ready handshake.
- Generalises the two-byte, little-endian collection used at bench level:
  - selectable byte order;
  - any word width that is a multiple of `DBIT`;
  - an inter-byte timeout that discards stale partial words;
  - a one-word output buffer with overrun reporting.

## Interface

Parameters:
- `DBIT`, default 8, bits per received byte.
- `NBITS_D`, default 16, output word width; must be an integer multiple of `DBIT` (`NBYTES = NBITS_D/DBIT`, range 1..8).
- `BYTE_ORDER`, default 0, byte placement:
  - 0 = first byte in LSBs (little-endian);
  - 1 = first byte in MSBs.
- `TIMEOUT_CYC`, default 2048, idle clocks allowed between bytes of one word; 0 disables the timeout.

Ports:
- `i_clk`, in, 1: system clock; all logic on rising edge.
- `i_rst`, in, 1: asynchronous, active-low reset.
- `i_rx_done`, in, 1: one-cycle strobe from `uart_rx`; byte on `i_rx_data` is valid.
- `i_rx_data`, in, `DBIT`: received byte.
- `i_flush`, in, 1: synchronous clear of partial word and output buffer.
- `i_ready`, in, 1: downstream accepts `o_data` when `o_valid && i_ready`.
- `o_data`, out, `NBITS_D`: assembled word, stable while `o_valid` is 1.
- `o_valid`, out, 1: output buffer holds an unaccepted word.
- `o_byte_cnt`, out, 3: bytes collected into the current partial word.
- `o_timeout`, out, 1: one-cycle pulse; partial word discarded.
- `o_overrun`, out, 1: one-cycle pulse; completed word dropped because buffer full.

## Operation

Reset state (`i_rst` = 0, asynchronous): all outputs are 0, the assembly register is 0, and the FSM is in IDLE.

FSM states:
- **IDLE**:
  - `o_byte_cnt` = 0.
  - `i_rx_done` → store byte 0.
    - If `NBYTES` = 1: complete the word immediately.
    - Else: go to COLLECT with count 1.
- **COLLECT**:
  - Each `i_rx_done` stores the byte at index = count and increments the count; the idle timer is cleared.
  - When the byte with index `NBYTES-1` is stored, the word is complete: count returns to 0, FSM returns to IDLE.
  - The idle timer increments on every cycle without `i_rx_done`.
  - When the timer reaches `TIMEOUT_CYC` (and `TIMEOUT_CYC` ≠ 0): discard the partial word, pulse `o_timeout`, go to IDLE.

Byte placement:
- Byte index k occupies bits `[k*DBIT +: DBIT]` when `BYTE_ORDER` = 0.
- Byte index k occupies bits `[(NBYTES-1-k)*DBIT +: DBIT]` when `BYTE_ORDER` = 1.

Word completion:
- If the buffer is empty, or is being accepted in the same cycle (`o_valid && i_ready`): load the word into `o_data` and set `o_valid`.
- Otherwise: drop the new word, keep the old `o_data`, pulse `o_overrun`.

Handshake:
- `o_valid` clears on acceptance unless a new word loads in the same cycle.
- `o_data` must not change while `o_valid` = 1 and not accepted.

Flush:
- `i_flush` = 1 clears the count, timer, and `o_valid`, and returns the FSM to IDLE.
- `i_flush` has priority over a simultaneous `i_rx_done`; that byte is dropped.

Assembly is independent of the output buffer: collection of the next word continues while `o_valid` = 1.

## Timing

- Completion latency: `o_valid` rises on the clock edge following the cycle in which the final `i_rx_done` is sampled (1 cycle).
- `o_byte_cnt` updates on the same edge that stores the byte.
- Timeout: with the last byte sampled at edge T, `o_timeout` is high during the cycle after edge `T+TIMEOUT_CYC`.
  - A byte sampled exactly at edge `T+TIMEOUT_CYC` wins: it is stored, the timer restarts, and there is no timeout.
- `o_timeout` and `o_overrun` are single-cycle registered pulses.
- `o_timeout` never fires in IDLE.
- Reset asserted mid-word clears everything immediately; the first byte after release is byte 0.

## Test plan

1. **Default little-endian assembly:** `NBITS_D`=16, `BYTE_ORDER`=0. Send 0x34 then 0x12 with `i_ready`=1 → `o_valid` pulses for one cycle with `o_data`=0x1234, one cycle after the second strobe.
2. **Wide big-endian word:** `NBITS_D`=32, `BYTE_ORDER`=1. Send 0xDE, 0xAD, 0xBE, 0xEF → `o_data`=0xDEADBEEF; `o_byte_cnt` steps 1, 2, 3, 0.
3. **Timeout discard:** `TIMEOUT_CYC`=20. Send 0x55, idle 20 cycles → `o_timeout` pulse, count 0. Then send 0x01, 0x02 → `o_data`=0x0201.
4. **Timeout boundary:** Send the second byte exactly 20 cycles after the first → no `o_timeout`; word completes normally.
5. **Overrun and same-cycle acceptance:**
   - With `i_ready`=0, send two full words 0x1111 and 0x2222 → `o_data` stays 0x1111, one `o_overrun` pulse.
   - Repeat with `i_ready` raised in the cycle the second word completes → `o_data`=0x2222, `o_valid` stays high, no overrun.
6. **Reset and flush mid-word:**
   - Assert `i_rst`=0 after one byte → all outputs 0 immediately.
   - Assert `i_flush` coincident with an `i_rx_done` → that byte is dropped; the next two bytes form a complete word.

Source files
------------

// File: rtl/uart_word_assembler.sv
// Receive-side deframer: packs NBITS_D/DBIT consecutive UART bytes into one word
// and holds it in a one-word valid/ready buffer with timeout and overrun pulses.
module uart_word_assembler #(
  parameter int DBIT        = 8,
  parameter int NBITS_D     = 16,
  parameter int BYTE_ORDER  = 0,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_done,
  input  logic [DBIT-1:0]    i_rx_data,
  input  logic               i_flush,
  input  logic               i_ready,
  output logic [NBITS_D-1:0] o_data,
  output logic               o_valid,
  output logic [2:0]         o_byte_cnt,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int NBYTES = NBITS_D / DBIT;
  localparam int TMR_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [2:0]       LAST_IDX = 3'(NBYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state;
  logic [NBITS_D-1:0] asm_word;
  logic [TMR_W-1:0]   timer;

  logic [NBITS_D-1:0] word_next;
  logic               last_byte;
  logic               timeout_hit;
  logic               accept;

  function automatic logic [NBITS_D-1:0] place_byte(input logic [NBITS_D-1:0] base,
                                                    input logic [2:0]         idx,
                                                    input logic [DBIT-1:0]    b);
    logic [NBITS_D-1:0] r;
    int                 pos;
    r   = base;
    pos = (BYTE_ORDER == 0) ? int'(idx) : (NBYTES - 1 - int'(idx));
    r[pos*DBIT +: DBIT] = b;
    return r;
  endfunction

  // A fresh word starts from zero so stale bytes of a discarded word never leak in.
  always_comb begin
    word_next   = place_byte((state == IDLE) ? '0 : asm_word, o_byte_cnt, i_rx_data);
    last_byte   = (o_byte_cnt == LAST_IDX);
    timeout_hit = (TIMEOUT_CYC != 0) && (state == COLLECT) && !i_rx_done && (timer == TMR_LAST);
    accept      = o_valid && i_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      asm_word   <= '0;
      timer      <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_byte_cnt <= 3'd0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
      if (i_flush) begin
        state      <= IDLE;
        asm_word   <= '0;
        timer      <= '0;
        o_valid    <= 1'b0;
        o_byte_cnt <= 3'd0;
      end else begin
        if (accept) o_valid <= 1'b0;
        if (i_rx_done) begin
          timer    <= '0;
          asm_word <= word_next;
          if (last_byte) begin
            state      <= IDLE;
            o_byte_cnt <= 3'd0;
            // A word accepted this cycle frees the buffer for the new one.
            if (!o_valid || i_ready) begin
              o_data  <= word_next;
              o_valid <= 1'b1;
            end else begin
              o_overrun <= 1'b1;
            end
          end else begin
            state      <= COLLECT;
            o_byte_cnt <= o_byte_cnt + 3'd1;
          end
        end else if (state == COLLECT) begin
          if (timeout_hit) begin
            state      <= IDLE;
            asm_word   <= '0;
            timer      <= '0;
            o_byte_cnt <= 3'd0;
            o_timeout  <= 1'b1;
          end else if (TIMEOUT_CYC != 0) begin
            timer <= timer + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// Bench for uart_word_assembler: 16-bit little-endian instance with a 20-cycle timeout
// checked against a queue-based model every cycle, plus a 32-bit big-endian instance.
module tb_uart_word_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        rx_done = 1'b0, flush = 1'b0, ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] data;
  logic        valid, to, ov;
  logic [2:0]  cnt;

  logic        rx_done_b = 1'b0, flush_b = 1'b0, ready_b = 1'b1;
  logic [7:0]  rx_data_b = 8'h00;
  logic [31:0] data_b;
  logic        valid_b, to_b, ov_b;
  logic [2:0]  cnt_b;

  uart_word_assembler #(.DBIT(8), .NBITS_D(16), .BYTE_ORDER(0), .TIMEOUT_CYC(20)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_flush(flush), .i_ready(ready), .o_data(data), .o_valid(valid),
    .o_byte_cnt(cnt), .o_timeout(to), .o_overrun(ov));

  uart_word_assembler #(.DBIT(8), .NBITS_D(32), .BYTE_ORDER(1), .TIMEOUT_CYC(0)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_rx_done(rx_done_b), .i_rx_data(rx_data_b),
    .i_flush(flush_b), .i_ready(ready_b), .o_data(data_b), .o_valid(valid_b),
    .o_byte_cnt(cnt_b), .o_timeout(to_b), .o_overrun(ov_b));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending bytes in a queue, idle clocks since the last byte, one-word buffer.
  logic [7:0]  pb[$];
  int          idle_cnt;
  logic        m_valid, m_to, m_ov;
  logic [15:0] m_data;

  task automatic model_reset();
    pb.delete();
    idle_cnt = 0;
    m_valid  = 1'b0;
    m_data   = 16'h0;
    m_to     = 1'b0;
    m_ov     = 1'b0;
  endtask

  task automatic model_step();
    logic        done;
    logic [15:0] w;
    done = 1'b0;
    w    = 16'h0;
    m_to = 1'b0;
    m_ov = 1'b0;
    if (flush) begin
      pb.delete();
      idle_cnt = 0;
      m_valid  = 1'b0;
    end else begin
      if (rx_done) begin
        pb.push_back(rx_data);
        idle_cnt = 0;
        if (pb.size() == 2) begin
          w = {8'h00, pb[0]} + ({8'h00, pb[1]} << 8);
          pb.delete();
          done = 1'b1;
        end
      end else if (pb.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == 20) begin
          pb.delete();
          idle_cnt = 0;
          m_to = 1'b1;
        end
      end
      if (done) begin
        if (!m_valid || ready) begin
          m_data  = w;
          m_valid = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) model_step();
      else model_reset();
      @(negedge clk);
      if (!rst_n) model_reset();
      check("cmp_valid", 64'(valid), 64'(m_valid));
      check("cmp_data", 64'(data), 64'(m_data));
      check("cmp_cnt", 64'(cnt), 64'(pb.size()));
      check("cmp_timeout", 64'(to), 64'(m_to));
      check("cmp_overrun", 64'(ov), 64'(m_ov));
    end
  end

  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rx_done_b = 1'b1;
    rx_data_b = b;
    @(negedge clk);
    rx_done_b = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(valid), 64'h0);
    check("rst_data", 64'(data), 64'h0);
    check("rst_cnt", 64'(cnt), 64'h0);
    check("rst_timeout", 64'(to), 64'h0);
    check("rst_overrun", 64'(ov), 64'h0);
    check("rst_data_b", 64'(data_b), 64'h0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);

    // Little-endian pair
    ready = 1'b1;
    send(8'h34);
    send(8'h12);
    check("le_valid", 64'(valid), 64'h1);
    check("le_data", 64'(data), 64'h1234);
    wait_cyc(1);
    check("le_valid_pulse", 64'(valid), 64'h0);

    // Big-endian 32-bit word
    send_b(8'hDE);
    check("be_cnt1", 64'(cnt_b), 64'h1);
    send_b(8'hAD);
    check("be_cnt2", 64'(cnt_b), 64'h2);
    send_b(8'hBE);
    check("be_cnt3", 64'(cnt_b), 64'h3);
    send_b(8'hEF);
    check("be_cnt0", 64'(cnt_b), 64'h0);
    check("be_valid", 64'(valid_b), 64'h1);
    check("be_data", 64'(data_b), 64'hDEADBEEF);
    check("be_no_timeout", 64'(to_b), 64'h0);
    wait_cyc(1);

    // Timeout discard
    send(8'h55);
    check("to_cnt1", 64'(cnt), 64'h1);
    wait_cyc(19);
    check("to_not_yet", 64'(to), 64'h0);
    wait_cyc(1);
    check("to_pulse", 64'(to), 64'h1);
    check("to_cnt0", 64'(cnt), 64'h0);
    wait_cyc(1);
    check("to_pulse_end", 64'(to), 64'h0);
    send(8'h01);
    send(8'h02);
    check("to_next_valid", 64'(valid), 64'h1);
    check("to_next_data", 64'(data), 64'h0201);
    wait_cyc(1);

    // Byte exactly at the timeout boundary wins
    send(8'hA5);
    wait_cyc(19);
    send(8'h5A);
    check("bnd_no_timeout", 64'(to), 64'h0);
    check("bnd_valid", 64'(valid), 64'h1);
    check("bnd_data", 64'(data), 64'h5AA5);
    wait_cyc(1);

    // Overrun with buffer full
    ready = 1'b0;
    send(8'h11);
    send(8'h11);
    check("ov_first_valid", 64'(valid), 64'h1);
    send(8'h22);
    send(8'h22);
    check("ov_pulse", 64'(ov), 64'h1);
    check("ov_data_kept", 64'(data), 64'h1111);
    check("ov_valid_kept", 64'(valid), 64'h1);
    wait_cyc(1);
    check("ov_pulse_end", 64'(ov), 64'h0);
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    check("ov_drained", 64'(valid), 64'h0);

    // Same-cycle acceptance replaces the buffered word
    send(8'h11);
    send(8'h11);
    send(8'h22);
    rx_done = 1'b1;
    rx_data = 8'h22;
    ready   = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    ready   = 1'b0;
    check("sc_data", 64'(data), 64'h2222);
    check("sc_valid", 64'(valid), 64'h1);
    check("sc_no_overrun", 64'(ov), 64'h0);
    ready = 1'b1;
    wait_cyc(1);
    check("sc_accepted", 64'(valid), 64'h0);

    // Flush beats a coincident byte
    send(8'hAA);
    rx_done = 1'b1;
    rx_data = 8'hBB;
    flush   = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    flush   = 1'b0;
    check("fl_cnt0", 64'(cnt), 64'h0);
    check("fl_valid0", 64'(valid), 64'h0);
    send(8'h03);
    check("fl_cnt1", 64'(cnt), 64'h1);
    send(8'h04);
    check("fl_valid", 64'(valid), 64'h1);
    check("fl_data", 64'(data), 64'h0403);
    wait_cyc(1);

    // Asynchronous reset mid-word
    send(8'h77);
    check("mr_cnt1", 64'(cnt), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_valid", 64'(valid), 64'h0);
    check("mr_data", 64'(data), 64'h0);
    check("mr_cnt", 64'(cnt), 64'h0);
    check("mr_data_b", 64'(data_b), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(1);
    send(8'h10);
    send(8'h20);
    check("mr_after_valid", 64'(valid), 64'h1);
    check("mr_after_data", 64'(data), 64'h2010);
    wait_cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
